// File: rtl/loop_nest_ctrl_pkg.sv
// Shared types and helpers for the loop-nest controller and its index stepper.
package loop_nest_ctrl_pkg;

  // Widest index the shared typedef carries; per-instance W must not exceed it.
  localparam int unsigned IDX_W     = 16;
  // Widest packed per-dimension bus the slice helper accepts.
  localparam int unsigned MAX_BUS_W = 256;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_e;

  // Extract field d of width w from a packed bus laid out as [d*w +: w].
  function automatic idx_t dim_slice(input logic [MAX_BUS_W-1:0] bus,
                                     input int unsigned          d,
                                     input int unsigned          w);
    logic [MAX_BUS_W-1:0] mask;
    mask = (MAX_BUS_W'(1) << w) - MAX_BUS_W'(1);
    return idx_t'((bus >> (d * w)) & mask);
  endfunction

endpackage

// File: rtl/nest_index_step.sv
// Combinational wrap/carry incrementer for an NDIMS-deep rectangular nest.
// Dim 0 is innermost; a dim at trip-1 wraps to 0 and carries upward.
module nest_index_step
  import loop_nest_ctrl_pkg::*;
#(
  parameter int unsigned NDIMS = 3,
  parameter int unsigned W     = 16
) (
  input  logic [NDIMS*W-1:0] idx,
  input  logic [NDIMS*W-1:0] trip,
  output logic [NDIMS*W-1:0] next_idx,
  output logic               is_first,
  output logic               is_last
);

  logic         w_carry;
  logic [W-1:0] w_cur;
  logic [W-1:0] w_lim;

  // Ripple the +1 from dim 0 upward while flagging all-zero and all-at-limit.
  always_comb begin
    next_idx = idx;
    is_first = 1'b1;
    is_last  = 1'b1;
    w_carry  = 1'b1;
    w_cur    = '0;
    w_lim    = '0;
    for (int unsigned d = 0; d < NDIMS; d++) begin
      w_cur = W'(dim_slice(MAX_BUS_W'(idx), d, W));
      w_lim = W'(dim_slice(MAX_BUS_W'(trip), d, W)) - W'(1);
      if (w_cur != '0) begin
        is_first = 1'b0;
      end
      if (w_cur != w_lim) begin
        is_last = 1'b0;
      end
      if (w_carry) begin
        if (w_cur == w_lim) begin
          next_idx[d*W +: W] = '0;
        end else begin
          next_idx[d*W +: W] = w_cur + W'(1);
          w_carry            = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/loop_nest_ctrl.sv
// Issues one iteration strobe per initiation interval across an NDIMS-deep
// loop nest with runtime trip counts and II; stall freezes the nest in place.
// A registered look-ahead (successor index and last flag of the index being
// presented) keeps the stepper off the state-decision path.
module loop_nest_ctrl
  import loop_nest_ctrl_pkg::*;
#(
  parameter int unsigned NDIMS = 3,
  parameter int unsigned W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic [NDIMS*W-1:0] trip_counts,
  input  logic [W-1:0]       ii,
  output logic               busy,
  output logic               valid,
  output logic [NDIMS*W-1:0] idx,
  output logic               first,
  output logic               last,
  output logic               done,
  output logic               start_dropped
);

  localparam int unsigned BUS_W = NDIMS * W;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [BUS_W-1:0] r_trip;
  logic [BUS_W-1:0] w_trip_nxt;
  logic [W-1:0]     r_iil;
  logic [W-1:0]     w_iil_nxt;
  logic [W-1:0]     r_gap;
  logic [W-1:0]     w_gap_nxt;
  logic [BUS_W-1:0] r_idx;
  logic [BUS_W-1:0] w_idx_nxt;
  logic [BUS_W-1:0] r_succ;
  logic             r_at_last;
  logic             w_valid_nxt;
  logic             w_done_nxt;
  logic             w_any_zero;

  logic [BUS_W-1:0] w_look_succ;
  logic             w_look_first;
  logic             w_look_last;

  logic             r_busy;
  logic             r_valid;
  logic             r_first;
  logic             r_last;
  logic             r_done;
  logic             r_drop;

  // Evaluate the index that will be presented next cycle.
  nest_index_step #(
    .NDIMS (NDIMS),
    .W     (W)
  ) u_look (
    .idx      (w_idx_nxt),
    .trip     (w_trip_nxt),
    .next_idx (w_look_succ),
    .is_first (w_look_first),
    .is_last  (w_look_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, config latch, gap counter and index advance.
  always_comb begin
    w_state_nxt = r_state;
    w_trip_nxt  = r_trip;
    w_iil_nxt   = r_iil;
    w_gap_nxt   = r_gap;
    w_idx_nxt   = r_idx;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_any_zero  = 1'b0;
    for (int unsigned d = 0; d < NDIMS; d++) begin
      if (W'(dim_slice(MAX_BUS_W'(trip_counts), d, W)) == '0) begin
        w_any_zero = 1'b1;
      end
    end
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_trip_nxt = trip_counts;
          w_iil_nxt  = (ii == '0) ? W'(1) : ii;
          w_idx_nxt  = '0;
          if (w_any_zero) begin
            w_state_nxt = FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = RUN;
            w_valid_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          if (r_at_last) begin
            w_state_nxt = FIN;
            w_done_nxt  = 1'b1;
          end else if (r_iil == W'(1)) begin
            w_idx_nxt   = r_succ;
            w_valid_nxt = 1'b1;
          end else begin
            w_idx_nxt   = r_succ;
            w_gap_nxt   = r_iil - W'(1);
            w_state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (!stall) begin
          if (r_gap == W'(1)) begin
            w_state_nxt = RUN;
            w_valid_nxt = 1'b1;
          end else begin
            w_gap_nxt = r_gap - W'(1);
          end
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trip    <= '0;
      r_iil     <= '0;
      r_gap     <= '0;
      r_idx     <= '0;
      r_succ    <= '0;
      r_at_last <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_trip    <= w_trip_nxt;
      r_iil     <= w_iil_nxt;
      r_gap     <= w_gap_nxt;
      r_idx     <= w_idx_nxt;
      r_succ    <= w_look_succ;
      r_at_last <= w_look_last;
      r_busy    <= (w_state_nxt != IDLE);
      r_valid   <= w_valid_nxt;
      r_first   <= w_valid_nxt & w_look_first;
      r_last    <= w_valid_nxt & w_look_last;
      r_done    <= w_done_nxt;
      r_drop    <= start & (r_state != IDLE);
    end
  end

  assign busy          = r_busy;
  assign valid         = r_valid;
  assign idx           = r_idx;
  assign first         = r_first;
  assign last          = r_last;
  assign done          = r_done;
  assign start_dropped = r_drop;

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// Self-checking bench for loop_nest_ctrl: default-width and W=4 instances.
`timescale 1ns/1ps
module tb_loop_nest_ctrl;

  localparam int unsigned NDIMS = 3;
  localparam int unsigned W     = 16;
  localparam int unsigned WN    = 4;

  typedef struct {
    int cyc;
    int d0;
    int d1;
    int d2;
    bit first;
    bit last;
  } strobe_t;

  logic clk = 1'b0;
  logic rst;
  logic start, stall;
  logic [NDIMS*W-1:0] trip_counts;
  logic [W-1:0] ii;
  logic busy, valid, first, last, done, start_dropped;
  logic [NDIMS*W-1:0] idx;

  logic start_w, stall_w;
  logic [NDIMS*WN-1:0] trip_w;
  logic [WN-1:0] ii_w;
  logic busy_w, valid_w, first_w, last_w, done_w, drop_w;
  logic [NDIMS*WN-1:0] idx_w;

  int n_checks = 0;
  int n_fail   = 0;
  strobe_t sb[$];

  always #5 clk = ~clk;

  loop_nest_ctrl #(.NDIMS(NDIMS), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .trip_counts(trip_counts), .ii(ii),
    .busy(busy), .valid(valid), .idx(idx), .first(first), .last(last),
    .done(done), .start_dropped(start_dropped)
  );

  loop_nest_ctrl #(.NDIMS(NDIMS), .W(WN)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .stall(stall_w),
    .trip_counts(trip_w), .ii(ii_w),
    .busy(busy_w), .valid(valid_w), .idx(idx_w), .first(first_w), .last(last_w),
    .done(done_w), .start_dropped(drop_w)
  );

  // Launch one nest at cycle 0, scoreboard its strobes, check per-cycle flags.
  // st_s/st_len: stall window; re_c: second start cycle; rst_c: reset cycle.
  task automatic run_nest(input string name, input bit wide,
                          input int t0, input int t1, input int t2, input int iiv,
                          input int st_s, input int st_len, input int re_c, input int rst_c,
                          output int n_busy, output int n_valid, output int n_drop,
                          output int done_at);
    int iil, n, c, t, cnt, done_c, last_c;
    strobe_t e, s;
    bit o_busy, o_valid, o_first, o_last, o_done, o_drop;
    int o_d0, o_d1, o_d2;
    bit exp_busy, exp_done, exp_drop, live;
    iil = (iiv == 0) ? 1 : iiv;
    n   = t0 * t1 * t2;
    sb.delete();
    c = 1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        cnt = 0;
        t   = c;
        while (cnt < iil) begin
          if (!(t >= st_s && t < st_s + st_len)) cnt++;
          t++;
        end
        c = t;
      end
      e.cyc = c; e.d0 = k % t0; e.d1 = (k / t0) % t1; e.d2 = k / (t0 * t1);
      e.first = (k == 0); e.last = (k == n - 1);
      if (rst_c < 0 || c <= rst_c) sb.push_back(e);
    end
    if (n == 0) begin
      done_c = 1;
    end else begin
      t = c;
      while (t >= st_s && t < st_s + st_len) t++;
      done_c = t + 1;
    end
    last_c  = (rst_c >= 0) ? rst_c + 4 : done_c + 3;
    n_busy  = 0;
    n_valid = 0;
    n_drop  = 0;
    done_at = -1;
    for (int cy = 0; cy <= last_c; cy++) begin
      @(negedge clk);
      if (wide) begin
        o_busy = busy_w; o_valid = valid_w; o_first = first_w; o_last = last_w;
        o_done = done_w; o_drop = drop_w;
        o_d0 = int'(idx_w[WN-1:0]); o_d1 = int'(idx_w[2*WN-1:WN]); o_d2 = int'(idx_w[3*WN-1:2*WN]);
      end else begin
        o_busy = busy; o_valid = valid; o_first = first; o_last = last;
        o_done = done; o_drop = start_dropped;
        o_d0 = int'(idx[W-1:0]); o_d1 = int'(idx[2*W-1:W]); o_d2 = int'(idx[3*W-1:2*W]);
      end
      live     = (rst_c < 0 || cy <= rst_c);
      exp_busy = live && cy >= 1 && cy <= done_c;
      exp_done = live && cy == done_c;
      exp_drop = live && re_c >= 1 && re_c <= done_c && cy == re_c + 1;
      n_checks++;
      if (o_busy !== exp_busy) begin
        n_fail++;
        $display("FAIL %s busy cyc %0d: got %0b want %0b", name, cy, o_busy, exp_busy);
      end
      n_checks++;
      if (o_done !== exp_done) begin
        n_fail++;
        $display("FAIL %s done cyc %0d: got %0b want %0b", name, cy, o_done, exp_done);
      end
      n_checks++;
      if (o_drop !== exp_drop) begin
        n_fail++;
        $display("FAIL %s start_dropped cyc %0d: got %0b want %0b", name, cy, o_drop, exp_drop);
      end
      n_checks++;
      if (!o_valid && (o_first || o_last)) begin
        n_fail++;
        $display("FAIL %s flags_without_valid cyc %0d: got first=%0b last=%0b want 0,0",
                 name, cy, o_first, o_last);
      end
      if (o_valid) begin
        n_valid++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_strobe cyc %0d: got valid=1 want no strobe", name, cy);
        end else begin
          s = sb.pop_front();
          if (s.cyc !== cy || s.d0 !== o_d0 || s.d1 !== o_d1 || s.d2 !== o_d2 ||
              s.first !== o_first || s.last !== o_last) begin
            n_fail++;
            $display("FAIL %s strobe: got cyc=%0d idx=(%0d,%0d,%0d) f=%0b l=%0b want cyc=%0d idx=(%0d,%0d,%0d) f=%0b l=%0b",
                     name, cy, o_d0, o_d1, o_d2, o_first, o_last,
                     s.cyc, s.d0, s.d1, s.d2, s.first, s.last);
          end
        end
      end
      if (o_busy) n_busy++;
      if (o_drop) n_drop++;
      if (o_done) done_at = cy;
      rst = (cy == rst_c);
      if (wide) begin
        start_w = (cy == 0) || (cy == re_c);
        stall_w = (cy >= st_s && cy < st_s + st_len);
        trip_w  = (cy == 0) ? {WN'(t2), WN'(t1), WN'(t0)} : (NDIMS*WN)'($urandom);
        ii_w    = (cy == 0) ? WN'(iiv) : WN'($urandom);
      end else begin
        start       = (cy == 0) || (cy == re_c);
        stall       = (cy >= st_s && cy < st_s + st_len);
        trip_counts = (cy == 0) ? {W'(t2), W'(t1), W'(t0)}
                                : {W'($urandom), W'($urandom), W'($urandom)};
        ii          = (cy == 0) ? W'(iiv) : W'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; stall = 1'b0; start_w = 1'b0; stall_w = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_strobes: got %0d unseen want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stall = 1'b0; start_w = 1'b1; stall_w = 1'b0;
    trip_counts = {W'(2), W'(2), W'(2)}; ii = W'(1);
    trip_w = {WN'(2), WN'(2), WN'(2)}; ii_w = WN'(1);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, valid, first, last, done, start_dropped} !== 6'b0 || idx !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got flags=%b idx=%h want 0", {busy, valid, first, last, done, start_dropped}, idx);
    end
    n_checks++;
    if ({busy_w, valid_w, first_w, last_w, done_w, drop_w} !== 6'b0 || idx_w !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_w: got flags=%b idx=%h want 0", {busy_w, valid_w, first_w, last_w, done_w, drop_w}, idx_w);
    end
    rst = 1'b0; start = 1'b0; start_w = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, valid, done} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy/valid/done=%b want 000", {busy, valid, done});
    end
  endtask

  task automatic test_basic_walk();
    int nb, nv, nd, da;
    run_nest("walk", 1'b0, 2, 3, 1, 1, -1, 0, -1, -1, nb, nv, nd, da);
    n_checks++;
    if (nb !== 7 || nv !== 6 || da !== 7) begin
      n_fail++;
      $display("FAIL walk_totals: got busy=%0d valid=%0d done@%0d want 7 6 7", nb, nv, da);
    end
  endtask

  task automatic test_ii_spacing();
    int nb, nv, nd, da;
    run_nest("ii3", 1'b0, 3, 1, 1, 3, -1, 0, -1, -1, nb, nv, nd, da);
    n_checks++;
    if (nv !== 3 || da !== 8) begin
      n_fail++;
      $display("FAIL ii3_totals: got valid=%0d done@%0d want 3 8", nv, da);
    end
    run_nest("ii0", 1'b0, 3, 1, 1, 0, -1, 0, -1, -1, nb, nv, nd, da);
    n_checks++;
    if (nv !== 3 || da !== 4) begin
      n_fail++;
      $display("FAIL ii0_totals: got valid=%0d done@%0d want 3 4", nv, da);
    end
    run_nest("ii2_nest", 1'b0, 3, 2, 2, 2, 4, 2, -1, -1, nb, nv, nd, da);
    n_checks++;
    if (nv !== 12) begin
      n_fail++;
      $display("FAIL ii2_nest_totals: got valid=%0d want 12", nv);
    end
  endtask

  task automatic test_stall();
    int nb, nv, nd, da;
    run_nest("stall", 1'b0, 4, 1, 1, 2, 2, 3, -1, -1, nb, nv, nd, da);
    n_checks++;
    if (nv !== 4 || da !== 11) begin
      n_fail++;
      $display("FAIL stall_totals: got valid=%0d done@%0d want 4 11", nv, da);
    end
  endtask

  task automatic test_zero_trip();
    int nb, nv, nd, da;
    run_nest("zero", 1'b0, 5, 0, 2, 1, -1, 0, -1, -1, nb, nv, nd, da);
    n_checks++;
    if (nv !== 0 || nb !== 1 || da !== 1) begin
      n_fail++;
      $display("FAIL zero_totals: got valid=%0d busy=%0d done@%0d want 0 1 1", nv, nb, da);
    end
  endtask

  task automatic test_collision();
    int nb, nv, nd, da;
    run_nest("collide", 1'b0, 2, 3, 1, 1, -1, 0, 3, -1, nb, nv, nd, da);
    n_checks++;
    if (nd !== 1 || nv !== 6 || da !== 7) begin
      n_fail++;
      $display("FAIL collide_totals: got drops=%0d valid=%0d done@%0d want 1 6 7", nd, nv, da);
    end
    run_nest("collide_fin", 1'b0, 2, 1, 1, 1, -1, 0, 3, -1, nb, nv, nd, da);
    n_checks++;
    if (nd !== 1 || nv !== 2) begin
      n_fail++;
      $display("FAIL collide_fin_totals: got drops=%0d valid=%0d want 1 2", nd, nv);
    end
  endtask

  task automatic test_reset_mid_run();
    int nb, nv, nd, da;
    run_nest("rst_mid", 1'b0, 2, 3, 1, 1, -1, 0, -1, 3, nb, nv, nd, da);
    n_checks++;
    if (nv !== 3 || da !== -1 || idx !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_totals: got valid=%0d done@%0d idx=%h want 3 -1 0", nv, da, idx);
    end
    run_nest("after_rst", 1'b0, 2, 3, 1, 1, -1, 0, -1, -1, nb, nv, nd, da);
    n_checks++;
    if (nv !== 6 || da !== 7) begin
      n_fail++;
      $display("FAIL after_rst_totals: got valid=%0d done@%0d want 6 7", nv, da);
    end
  endtask

  task automatic test_wide();
    int nb, nv, nd, da;
    run_nest("wide", 1'b1, 15, 2, 1, 1, -1, 0, -1, -1, nb, nv, nd, da);
    n_checks++;
    if (nv !== 30 || da !== 31 || nb !== 31) begin
      n_fail++;
      $display("FAIL wide_totals: got valid=%0d done@%0d busy=%0d want 30 31 31", nv, da, nb);
    end
  endtask

  initial begin
    test_reset();
    test_basic_walk();
    test_ii_spacing();
    test_stall();
    test_zero_trip();
    test_collision();
    test_reset_mid_run();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
